// File: rtl/data_path_pkg.sv
// Shared constants for the data_path slice: ALU opcodes, bus source
// selects and CCR bit positions.
package data_path_pkg;

  // ALU operation select codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_INC = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_DEC = 3'b110;
  localparam logic [2:0] ALU_NOT = 3'b111;

  // Bus1 source selects
  localparam logic [1:0] BUS1_PC   = 2'b00;
  localparam logic [1:0] BUS1_A    = 2'b01;
  localparam logic [1:0] BUS1_B    = 2'b10;
  localparam logic [1:0] BUS1_ZERO = 2'b11;

  // Bus2 source selects
  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;
  localparam logic [1:0] BUS2_ZERO = 2'b11;

  // CCR bit indices, flags packed as {N,Z,V,C}
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

endpackage

// File: rtl/data_path_alu.sv
// Combinational 8-bit ALU with N/Z/V/C flag generation.
// C is carry-out for add/inc and borrow for sub/dec; V is signed overflow.
// Logic ops clear V and C.
module data_path_alu
  import data_path_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] alu_sel,
  output logic [7:0] result,
  output logic [3:0] flags
);

  logic [8:0] wide;
  logic       v_flag;
  logic       c_flag;

  // Operation select, result and arithmetic flags
  always_comb begin
    wide   = 9'd0;
    result = 8'h00;
    v_flag = 1'b0;
    c_flag = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[7:0];
        c_flag = wide[8];
        v_flag = (a[7] == b[7]) && (result[7] != a[7]);
      end
      ALU_INC: begin
        wide   = {1'b0, a} + 9'd1;
        result = wide[7:0];
        c_flag = wide[8];
        v_flag = ~a[7] & result[7];
      end
      ALU_SUB: begin
        // Bit 8 of the 9-bit difference is set exactly when a < b
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[7:0];
        c_flag = wide[8];
        v_flag = (a[7] != b[7]) && (result[7] != a[7]);
      end
      ALU_DEC: begin
        wide   = {1'b0, a} - 9'd1;
        result = wide[7:0];
        c_flag = wide[8];
        v_flag = a[7] & ~result[7];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      default: result = 8'h00;
    endcase
  end

  // Pack flags into CCR layout
  always_comb begin
    flags        = 4'b0000;
    flags[CCR_N] = result[7];
    flags[CCR_Z] = (result == 8'h00);
    flags[CCR_V] = v_flag;
    flags[CCR_C] = c_flag;
  end

endmodule

// File: rtl/data_path.sv
// Processor data path: two source buses, IR/MAR/PC/A/B/CCR registers and
// an ALU sub-module. Every enabled register loads the same Bus2 value on a
// clock edge; PC_Load beats PC_Inc; Reset beats everything.
// Optional simulation checks are compiled in with DATA_PATH_ASSERT_EN.
module data_path
  import data_path_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] from_memory,
  input  logic [2:0] ALU_Sel,
  input  logic [1:0] Bus1_Sel,
  input  logic [1:0] Bus2_Sel,
  input  logic       IR_Load,
  input  logic       MAR_Load,
  input  logic       PC_Load,
  input  logic       A_Load,
  input  logic       B_Load,
  input  logic       CCR_Load,
  input  logic       PC_Inc,
  output logic [7:0] address,
  output logic [7:0] to_memory,
  output logic [7:0] IR_out,
  output logic [3:0] CCR_Result
);

  logic [7:0] ir_q, mar_q, pc_q, a_q, b_q;
  logic [3:0] ccr_q;
  logic [7:0] bus1, bus2;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;

  data_path_alu u_alu (
    .a       (a_q),
    .b       (b_q),
    .alu_sel (ALU_Sel),
    .result  (alu_result),
    .flags   (alu_flags)
  );

  // Bus1 source mux
  always_comb begin
    bus1 = 8'h00;
    case (Bus1_Sel)
      BUS1_PC:   bus1 = pc_q;
      BUS1_A:    bus1 = a_q;
      BUS1_B:    bus1 = b_q;
      default:   bus1 = 8'h00;
    endcase
  end

  // Bus2 source mux
  always_comb begin
    bus2 = 8'h00;
    case (Bus2_Sel)
      BUS2_ALU:  bus2 = alu_result;
      BUS2_BUS1: bus2 = bus1;
      BUS2_MEM:  bus2 = from_memory;
      default:   bus2 = 8'h00;
    endcase
  end

  // Register file update; reset overrides all load and increment enables
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ir_q  <= 8'h00;
      mar_q <= 8'h00;
      pc_q  <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      ccr_q <= 4'b0000;
    end else begin
      if (IR_Load)  ir_q  <= bus2;
      if (MAR_Load) mar_q <= bus2;
      if (A_Load)   a_q   <= bus2;
      if (B_Load)   b_q   <= bus2;
      if (CCR_Load) ccr_q <= alu_flags;
      if (PC_Load)     pc_q <= bus2;
      else if (PC_Inc) pc_q <= pc_q + 8'd1;
    end
  end

  assign address    = mar_q;
  assign to_memory  = bus1;
  assign IR_out     = ir_q;
  assign CCR_Result = ccr_q;

`ifdef DATA_PATH_ASSERT_EN
  logic any_load;
  assign any_load = IR_Load | MAR_Load | PC_Load | A_Load | B_Load | CCR_Load;

  // Flag undefined controls and zero-source selects while something is loading
  always @(posedge Clk) begin
    if (!Reset) begin
      assert (!$isunknown({ALU_Sel, Bus1_Sel, Bus2_Sel, IR_Load, MAR_Load,
                           PC_Load, A_Load, B_Load, CCR_Load, PC_Inc}))
        else $error("data_path: control input is X/Z");
      assert (!(any_load && (Bus1_Sel == BUS1_ZERO || Bus2_Sel == BUS2_ZERO)))
        else $error("data_path: zero bus source selected while a load is enabled");
    end
  end
`endif

endmodule

// File: tb/tb_data_path.sv
// Directed plus short randomized bench for data_path. Expected values are
// pushed to exp_q when stimulus is driven and popped when outputs are sampled.
module tb_data_path;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] from_memory;
  logic [2:0] alu_sel;
  logic [1:0] bus1_sel, bus2_sel;
  logic       ir_load, mar_load, pc_load, a_load, b_load, ccr_load, pc_inc;
  logic [7:0] address, to_memory, ir_out;
  logic [3:0] ccr_result;

  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  data_path dut (
    .Clk         (clk),
    .Reset       (reset),
    .from_memory (from_memory),
    .ALU_Sel     (alu_sel),
    .Bus1_Sel    (bus1_sel),
    .Bus2_Sel    (bus2_sel),
    .IR_Load     (ir_load),
    .MAR_Load    (mar_load),
    .PC_Load     (pc_load),
    .A_Load      (a_load),
    .B_Load      (b_load),
    .CCR_Load    (ccr_load),
    .PC_Inc      (pc_inc),
    .address     (address),
    .to_memory   (to_memory),
    .IR_out      (ir_out),
    .CCR_Result  (ccr_result)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    from_memory = 8'h00;
    alu_sel     = 3'b000;
    bus1_sel    = 2'b00;
    bus2_sel    = 2'b00;
    ir_load  = 1'b0; mar_load = 1'b0; pc_load = 1'b0;
    a_load   = 1'b0; b_load   = 1'b0; ccr_load = 1'b0;
    pc_inc   = 1'b0;
  endtask

  // driver: put a memory value on Bus2 and load one register (0 IR,1 PC,2 A,3 B)
  task automatic load_mem(input int which, input logic [7:0] val);
    clear_ctrl();
    bus2_sel    = 2'b10;
    from_memory = val;
    case (which)
      0: ir_load = 1'b1;
      1: pc_load = 1'b1;
      2: a_load  = 1'b1;
      default: b_load = 1'b1;
    endcase
    tick();
    clear_ctrl();
  endtask

  // scoreboard: pop one expected value and compare
  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %h, expected queue empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // reference ALU using integer arithmetic; returns {flags, result}
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    int ua, ub, sa, sb, r, sr;
    logic n, z, v, c;
    logic [7:0] res;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; sr = 0; v = 1'b0; c = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; sr = sa + sb; c = (r > 255); end
      3'd1: begin r = ua + 1;  sr = sa + 1;  c = (r > 255); end
      3'd2: begin r = ua - ub; sr = sa - sb; c = (ua < ub); end
      3'd6: begin r = ua - 1;  sr = sa - 1;  c = (ua < 1);  end
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      default: r = 255 - ua;
    endcase
    if (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd6)
      v = (sr > 127) || (sr < -128);
    res = 8'(r & 255);
    n = res[7];
    z = (res == 8'h00);
    return {n, z, v, c, res};
  endfunction

  // ALU op with simultaneous MAR and CCR load; checks result and flags
  task automatic alu_step(input string tag, input logic [2:0] op,
                          input logic [7:0] exp_res, input logic [3:0] exp_ccr);
    clear_ctrl();
    alu_sel  = op;
    bus2_sel = 2'b00;
    mar_load = 1'b1;
    ccr_load = 1'b1;
    exp_q.push_back(exp_res);
    exp_q.push_back({4'h0, exp_ccr});
    tick();
    clear_ctrl();
    check({tag, "_res"}, address);
    check({tag, "_ccr"}, {4'h0, ccr_result});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] rop;
    logic [11:0] m;

    clear_ctrl();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    exp_q.push_back(8'h00); check("rst_address", address);
    exp_q.push_back(8'h00); check("rst_ir", ir_out);
    exp_q.push_back(8'h00); check("rst_ccr", {4'h0, ccr_result});
    exp_q.push_back(8'h00); check("rst_to_memory", to_memory);

    // memory loads through Bus2
    load_mem(0, 8'h45);
    load_mem(1, 8'hE8);
    load_mem(2, 8'h18);
    load_mem(3, 8'hBB);
    exp_q.push_back(8'h45); check("ir_load", ir_out);
    bus1_sel = 2'b00; #1; exp_q.push_back(8'hE8); check("bus1_pc", to_memory);
    bus1_sel = 2'b01; #1; exp_q.push_back(8'h18); check("bus1_a", to_memory);
    bus1_sel = 2'b10; #1; exp_q.push_back(8'hBB); check("bus1_b", to_memory);
    bus1_sel = 2'b11; #1; exp_q.push_back(8'h00); check("bus1_zero", to_memory);
    clear_ctrl();

    // ALU with A=0x18, B=0xBB
    alu_step("add", 3'b000, 8'hD3, 4'b1000);
    alu_step("sub", 3'b010, 8'h5D, 4'b0001);
    alu_step("not", 3'b111, 8'hE7, 4'b1000);

    // overflow and zero corners
    load_mem(2, 8'h7F);
    load_mem(3, 8'h01);
    alu_step("add_ovf", 3'b000, 8'h80, 4'b1010);
    load_mem(2, 8'h01);
    alu_step("dec_zero", 3'b110, 8'h00, 4'b0100);

    // CCR holds when CCR_Load is low
    alu_sel = 3'b000;
    exp_q.push_back(8'h04);
    tick();
    check("ccr_hold", {4'h0, ccr_result});

    // PC wrap and load priority
    load_mem(1, 8'hFF);
    pc_inc = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    clear_ctrl();
    check("pc_wrap", to_memory);
    pc_inc = 1'b1; pc_load = 1'b1; bus2_sel = 2'b10; from_memory = 8'h33;
    exp_q.push_back(8'h33);
    tick();
    clear_ctrl();
    check("pc_load_wins", to_memory);
    pc_inc = 1'b1;
    exp_q.push_back(8'h34);
    tick();
    clear_ctrl();
    check("pc_inc", to_memory);

    // simultaneous loads of A, B, IR from Bus1=PC via Bus2
    bus1_sel = 2'b00; bus2_sel = 2'b01;
    a_load = 1'b1; b_load = 1'b1; ir_load = 1'b1;
    exp_q.push_back(8'h34); exp_q.push_back(8'h34); exp_q.push_back(8'h34);
    tick();
    clear_ctrl();
    check("multi_ir", ir_out);
    bus1_sel = 2'b01; #1; check("multi_a", to_memory);
    bus1_sel = 2'b10; #1; check("multi_b", to_memory);
    clear_ctrl();

    // randomized ALU ops against the integer model
    for (int i = 0; i < 12; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 3'($urandom_range(0, 7));
      load_mem(2, ra);
      load_mem(3, rb);
      m = alu_model(ra, rb, rop);
      alu_step($sformatf("rand%0d_op%0d", i, rop), rop, m[7:0], m[11:8]);
    end

    // reset overrides pending loads
    bus2_sel = 2'b10; from_memory = 8'hAA;
    ir_load = 1'b1; mar_load = 1'b1; pc_load = 1'b1; ccr_load = 1'b1; pc_inc = 1'b1;
    reset = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    tick();
    clear_ctrl();
    reset = 1'b0;
    check("rst2_address", address);
    check("rst2_ir", ir_out);
    check("rst2_ccr", {4'h0, ccr_result});
    check("rst2_pc", to_memory);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_drain: observed %0d leftover, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 from_memory  input  8  read data from memory.
REQ-004 ALU_Sel  input  3  ALU operation select.
REQ-005 Bus1_Sel  input  2  Bus1 source select.
REQ-006 Bus2_Sel  input  2  Bus2 source select.
REQ-007 IR_Load, MAR_Load, PC_Load, A_Load, B_Load, CCR_Load  input  1 each  register load enables.
REQ-008 PC_Inc  input  1  PC increment enable.
REQ-009 address  output  8  MAR contents.
REQ-010 to_memory  output  8  Bus1 value.
REQ-011 IR_out  output  8  IR contents.
REQ-012 CCR_Result  output  4  CCR contents {N,Z,V,C}, N at bit 3.

Function
REQ-013 Bus1 (combinational) SHALL be: 00 PC, 01 A, 10 B, 11 8'h00.
REQ-014 Bus2 (combinational) SHALL be: 00 ALU result, 01 Bus1, 10 from_memory, 11 8'h00.
REQ-015 IR, MAR, A, B SHALL each load Bus2 on a clock edge when their load enable is 1, else hold.
REQ-016 PC SHALL load Bus2 when PC_Load=1, else increment mod 256 (0xFF -> 0x00) when PC_Inc=1, else hold; PC_Load wins when both are high.
REQ-017 CCR SHALL load the ALU flags when CCR_Load=1, else hold.
REQ-018 ALU operands SHALL be registers A and B; result 8-bit, combinational. ALU_Sel: 000 A+B, 001 A+1, 010 A-B, 011 A&B, 100 A|B, 101 A^B, 110 A-1, 111 ~A.
REQ-019 N=result[7]; Z=(result==0).
REQ-020 For add and increment ops: C=carry out of bit 7; V=signed two's-complement overflow.
REQ-021 For subtract and decrement ops: C=borrow (1 when unsigned minuend < subtrahend); V=signed overflow.
REQ-022 For logic ops (011, 100, 101, 111): V=0, C=0.
REQ-023 Multiple simultaneous load enables SHALL all take effect in the same cycle from the same Bus2 value.
REQ-024 Outputs SHALL reflect register state one cycle after the load edge; to_memory follows Bus1 combinationally.

Reset
REQ-025 When Reset=1 at a rising edge, IR, MAR, PC, A, B SHALL become 8'h00 and CCR SHALL become 4'b0000, overriding all load and increment enables.
REQ-026 Outputs after reset SHALL be: address=0x00, IR_out=0x00, CCR_Result=0000, to_memory=Bus1 of the reset registers (0x00).

Configuration
REQ-027 With DATA_PATH_ASSERT_EN defined, simulation checks SHALL report an error when Bus1_Sel or Bus2_Sel is 2'b11 while any load enable is high, or when any control input is X/Z outside reset.
REQ-028 Without DATA_PATH_ASSERT_EN, no checks SHALL be present; synthesized logic SHALL be identical in both cases.

Structure
REQ-029 Package data_path_pkg SHALL hold ALU_Sel opcodes, Bus1/Bus2 select constants, and CCR bit indices (N=3, Z=2, V=1, C=0).
REQ-030 The ALU and flag generation SHALL be a sub-module named data_path_alu; bus muxes and registers SHALL reside in data_path.

Verification
REQ-031 Reset -> address=0x00, IR_out=0x00, CCR_Result=0000, to_memory=0x00.
REQ-032 Bus2_Sel=10 with from_memory 0x45, 0xE8, 0x18, 0xBB, loading IR, PC, A, B in turn -> IR_out=0x45; to_memory=0xE8 (Bus1_Sel=00), 0x18 (01), 0xBB (10).
REQ-033 A=0x18, B=0xBB: ALU_Sel=000 with CCR_Load -> CCR_Result=1000 (0xD3); ALU_Sel=010 -> 0001 (0x5D, borrow); ALU_Sel=111 -> 1000 (0xE7).
REQ-034 ALU_Sel=111, Bus2_Sel=00, MAR_Load=1 -> address=0xE7 next cycle.
REQ-035 A=0x7F, B=0x01, ALU_Sel=000, CCR_Load -> CCR_Result=1010; A=0x01, ALU_Sel=110 -> 0100.
REQ-036 PC=0xFF, PC_Inc=1 -> PC=0x00; PC_Inc=1 and PC_Load=1 with Bus2=0x33 -> PC=0x33.
